bidirectional_dual_port_ram: RTL and testbench
==============================================

# bidirectional_dual_port_ram

Parametrised simple dual-port RAM with one write port and one read port. Both ports accept Python-style signed indices: negative indices count back from the end of the array. Adds bounds checking with error flags, a read-valid strobe with selectable read latency, and a hardware clear engine that zero-fills the array after reset or on request. It is the list/array storage primitive behind synthesised sequences that need concurrent read and write plus negative indexing.

## Interface
- DATA_WIDTH, 8, word width.
- ADDR_WIDTH, 5, signed index width; physical depth is 2^ADDR_WIDTH.
- RAM_LENGTH, 16, logical length; legal range 1..2^(ADDR_WIDTH-1).
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- CLEAR_ON_RESET, 1, 1 = zero-fill the array automatically after reset release.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- WE  in  1  write request.
- WADDR  in  ADDR_WIDTH  signed write index.
- D  in  DATA_WIDTH  write data.
- RE  in  1  read request.
- RADDR  in  ADDR_WIDTH  signed read index.
- Q  out  DATA_WIDTH  read data.
- QV  out  1  read-valid strobe, one cycle per accepted read.
- RERR  out  1  out-of-range read flag, aligned with QV.
- WERR  out  1  out-of-range write flag, one-cycle pulse.
- CLR  in  1  start a clear operation.
- BUSY  out  1  clear in progress; port requests are ignored while high.
- LEN  out  ADDR_WIDTH  constant RAM_LENGTH.

## Operation
- **Index translation** (identical for both ports). Index i is two's complement.
  - i ≥ 0 and i < RAM_LENGTH: physical = i.
  - i < 0 and i ≥ −RAM_LENGTH: physical = RAM_LENGTH + i, computed mod 2^ADDR_WIDTH.
  - Any other index is out of range.
- **Write.** Accepted when WE=1 and BUSY=0.
  - In range: mem[phys] ← D.
  - Out of range: the write is dropped and WERR=1 on the next cycle.
- **Read.** Accepted when RE=1 and BUSY=0.
  - In range: Q returns mem[phys].
  - Out of range: Q returns 0 with RERR=1.
  - QV and RERR pulse for exactly one cycle per accepted read.
  - Q holds its last value when no read completes.
- **Read-during-write.** When both ports hit the same physical address in the same cycle, the read returns the new D (write-first, bypass). This also holds for aliased indices, e.g. −1 and RAM_LENGTH−1.
- **Clear FSM.** States IDLE and CLEAR. A counter cnt spans 0..RAM_LENGTH−1.
  - IDLE → CLEAR when CLR=1 (cnt ← 0).
  - In CLEAR, each cycle writes mem[cnt] ← 0 and increments cnt.
  - After the write to RAM_LENGTH−1, the FSM returns to IDLE.
  - CLR is ignored while in CLEAR.
  - BUSY = (state == CLEAR).
- **Requests while BUSY.** WE and RE are ignored: no write, no QV, no RERR/WERR.
- **Unused storage.** Physical locations ≥ RAM_LENGTH are never written or read.

## Timing
- **Reset (RST=0).** Asynchronous.
  - Q=0, QV=0, RERR=0, WERR=0, pipeline registers cleared, cnt=0.
  - State = CLEAR if CLEAR_ON_RESET=1, else IDLE, so BUSY=CLEAR_ON_RESET during reset.
  - Memory contents are not reset asynchronously.
- **After reset release with CLEAR_ON_RESET=1.** BUSY stays high for exactly RAM_LENGTH rising edges, then falls. A request presented on the first cycle with BUSY=0 is accepted.
- **Reset asserted mid-clear.** Aborts immediately. The clear restarts from cnt=0 after release when CLEAR_ON_RESET=1; otherwise the array is left partially cleared.
- **Read latency.**
  - OUT_REG=0: RE sampled at edge N gives Q/QV/RERR valid after edge N+1.
  - OUT_REG=1: valid after edge N+2.
  - Fully pipelined, one read per cycle; back-to-back reads give back-to-back QV.
- **Write timing.** Data is visible to a read issued at the next edge. WERR is valid after edge N+1 for a write sampled at edge N, independent of OUT_REG.
- **CLR timing.** CLR sampled high at edge N in IDLE gives BUSY=1 after edge N. A read accepted before that edge still completes with QV at its normal latency.

## Test plan
- **Reset clear.** CLEAR_ON_RESET=1, RAM_LENGTH=16: release RST, count BUSY → exactly 16 cycles high. Then read indices 0..15 → Q=0, QV each cycle, RERR=0.
- **Negative indexing.** Write D=0xA5 at index −1 (5'h1F), then read index 15 → Q=0xA5. Write 0x3C at index 0, read index −16 (5'h10) → 0x3C.
- **Bounds.** Write at index 16 → WERR=1 one cycle later; memory is unchanged. Read index −17 → QV=1, RERR=1, Q=0.
- **Read-during-write.** Same cycle: WE index 3, D=0x77; RE index −13 → Q=0x77 at the read latency. Repeat with OUT_REG=1 → result arrives one cycle later.
- **CLR during traffic.** Assert CLR while issuing RE/WE every cycle:
  - BUSY high for 16 cycles.
  - No QV or WERR for requests issued during BUSY.
  - Previously written data reads 0 afterwards.
- **Reset mid-clear.** Drop RST at clear cycle 7, hold 2 cycles, release → BUSY high for a full 16 cycles and all outputs 0 during reset.

Source files
------------

// File: rtl/bidirectional_dual_port_ram.sv
// bidirectional_dual_port_ram
// Simple dual-port RAM (one write port, one read port) addressed by signed,
// Python-style indices: negative indices count back from the logical end.
// Includes bounds checking, a read-valid strobe with 1- or 2-cycle read
// latency, and a clear engine that zero-fills the array after reset and on
// request.
//
// Ports:
//   CLK    clock, rising edge
//   RST    asynchronous active-low reset
//   WE     write request          WADDR  signed write index   D  write data
//   RE     read request           RADDR  signed read index
//   Q      read data (holds when no read completes)
//   QV     read-valid strobe      RERR   out-of-range read (aligned with QV)
//   WERR   out-of-range write pulse, one cycle after the write
//   CLR    start a clear          BUSY   clear in progress, requests ignored
//   LEN    constant logical length
module bidirectional_dual_port_ram #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 5,
  parameter int RAM_LENGTH     = 16,
  parameter bit OUT_REG        = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WADDR,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  RE,
  input  logic [ADDR_WIDTH-1:0] RADDR,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  QV,
  output logic                  RERR,
  output logic                  WERR,
  input  logic                  CLR,
  output logic                  BUSY,
  output logic [ADDR_WIDTH-1:0] LEN
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_e;

  typedef struct packed {
    logic                  ok;
    logic [ADDR_WIDTH-1:0] phys;
  } xlat_t;

  // Signed index -> physical address. Negative indices wrap by adding the
  // logical length modulo 2^ADDR_WIDTH, so -1 and RAM_LENGTH-1 alias.
  function automatic xlat_t translate(input logic [ADDR_WIDTH-1:0] idx);
    xlat_t r;
    int    s;
    s      = int'($signed(idx));
    r.ok   = 1'b0;
    r.phys = '0;
    if (s >= 0 && s < RAM_LENGTH) begin
      r.ok   = 1'b1;
      r.phys = idx;
    end else if (s < 0 && s >= -RAM_LENGTH) begin
      r.ok   = 1'b1;
      r.phys = idx + ADDR_WIDTH'(RAM_LENGTH);
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  werr_q, werr_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_err_q, s1_err_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

  xlat_t                 wx, rx;
  logic                  wr_acc, rd_acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign BUSY   = (state_q == CLEAR);
  assign LEN    = ADDR_WIDTH'(RAM_LENGTH);
  assign wx     = translate(WADDR);
  assign rx     = translate(RADDR);
  assign wr_acc = WE && !BUSY;
  assign rd_acc = RE && !BUSY;

  // Clear FSM plus write-port arbitration. The clear engine owns the write
  // port while BUSY; user requests are ignored then, so there is no conflict.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_addr  = WADDR;
    mem_wdata = D;
    werr_d    = wr_acc && !wx.ok;
    unique case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
        if (wr_acc && wx.ok) begin
          mem_we   = 1'b1;
          mem_addr = wx.phys;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        if (cnt_q == ADDR_WIDTH'(RAM_LENGTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // First read stage: write-first bypass when both ports hit the same
  // physical word; out-of-range reads return zero.
  always_comb begin
    s1_valid_d = rd_acc;
    s1_err_d   = rd_acc && !rx.ok;
    s1_data_d  = s1_data_q;
    if (rd_acc) begin
      if (!rx.ok)
        s1_data_d = '0;
      else if (wr_acc && wx.ok && (wx.phys == rx.phys))
        s1_data_d = D;
      else
        s1_data_d = mem[rx.phys];
    end
  end

  // NOTE: storage has no reset; contents are zeroed by the clear engine, which
  // keeps the array mappable onto RAM primitives.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt_q      <= '0;
      werr_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      werr_q     <= werr_d;
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      s1_data_q  <= s1_data_d;
    end
  end

  assign WERR = werr_q;

  generate
    if (OUT_REG) begin : g_out_reg
      logic                  s2_valid_q, s2_valid_d;
      logic                  s2_err_q, s2_err_d;
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_err_d   = s1_err_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          s2_valid_q <= 1'b0;
          s2_err_q   <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_err_q   <= s2_err_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign Q    = s2_data_q;
      assign QV   = s2_valid_q;
      assign RERR = s2_err_q;
    end else begin : g_no_out_reg
      assign Q    = s1_data_q;
      assign QV   = s1_valid_q;
      assign RERR = s1_err_q;
    end
  endgenerate

endmodule

// File: tb/tb_bidirectional_dual_port_ram.sv
// Directed bench for bidirectional_dual_port_ram. Two instances share all
// inputs: u_dut0 with read latency 1, u_dut1 with read latency 2. A 6-bit
// index with length 16 leaves room for genuinely out-of-range indices
// (16..31 and -17..-32).
module tb_bidirectional_dual_port_ram;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int RL = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          WE, RE, CLR;
  logic [AW-1:0] WADDR, RADDR;
  logic [DW-1:0] D;

  logic [DW-1:0] q0, q1;
  logic          qv0, qv1, rerr0, rerr1, werr0, werr1, busy0, busy1;
  logic [AW-1:0] len0, len1;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  bidirectional_dual_port_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LENGTH(RL),
    .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)
  ) u_dut0 (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .D(D), .RE(RE),
    .RADDR(RADDR), .Q(q0), .QV(qv0), .RERR(rerr0), .WERR(werr0),
    .CLR(CLR), .BUSY(busy0), .LEN(len0)
  );

  bidirectional_dual_port_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LENGTH(RL),
    .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1)
  ) u_dut1 (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .D(D), .RE(RE),
    .RADDR(RADDR), .Q(q1), .QV(qv1), .RERR(rerr1), .WERR(werr1),
    .CLR(CLR), .BUSY(busy1), .LEN(len1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic exp_werr);
    WE = 1'b1; WADDR = a; D = d;
    step();
    WE = 1'b0;
    check("werr0", 32'(werr0), 32'(exp_werr));
    check("werr1", 32'(werr1), 32'(exp_werr));
    step();
    check("werr0_pulse", 32'(werr0), 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_q,
                         input logic exp_err);
    RE = 1'b1; RADDR = a;
    step();
    RE = 1'b0;
    check("qv0",   32'(qv0),   32'd1);
    check("q0",    32'(q0),    32'(exp_q));
    check("rerr0", 32'(rerr0), 32'(exp_err));
    check("qv1_early", 32'(qv1), 32'd0);
    step();
    check("qv0_pulse", 32'(qv0), 32'd0);
    check("qv1",   32'(qv1),   32'd1);
    check("q1",    32'(q1),    32'(exp_q));
    check("rerr1", 32'(rerr1), 32'(exp_err));
  endtask

  // Counts falling-edge samples with BUSY high, starting from the current one.
  task automatic count_busy(output int n);
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_q0"},    32'(q0),    32'd0);
    check({tag, "_q1"},    32'(q1),    32'd0);
    check({tag, "_qv"},    32'({qv0, qv1}),     32'd0);
    check({tag, "_err"},   32'({rerr0, rerr1, werr0, werr1}), 32'd0);
    check({tag, "_busy"},  32'({busy0, busy1}), 32'b11);
  endtask

  initial begin
    int n;
    RST = 1'b0; WE = 1'b0; RE = 1'b0; CLR = 1'b0;
    WADDR = '0; RADDR = '0; D = '0;

    // Reset state, then the automatic clear after release.
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    check("len", 32'(len0), 32'd16);
    RST = 1'b1;
    count_busy(n);
    check("rst_clear_cycles", n, 32'd16);
    check("busy1_low", 32'(busy1), 32'd0);

    // Back-to-back reads of the cleared array; first idle cycle is accepted.
    for (int i = 0; i < RL; i++) begin
      RE = 1'b1; RADDR = AW'(i);
      step();
      check("clr_rd_qv0", 32'(qv0), 32'd1);
      check("clr_rd_q0",  32'(q0),  32'd0);
      check("clr_rd_rerr0", 32'(rerr0), 32'd0);
      if (i > 0) check("clr_rd_qv1", 32'(qv1), 32'd1);
    end
    RE = 1'b0;
    step();
    check("clr_rd_qv1_last", 32'(qv1), 32'd1);
    check("clr_rd_qv0_end",  32'(qv0), 32'd0);

    // Negative indexing and aliasing.
    do_write(6'h3F, 8'hA5, 1'b0);   // -1 -> phys 15
    do_read(6'd15, 8'hA5, 1'b0);
    do_write(6'd0, 8'h3C, 1'b0);
    do_read(6'h30, 8'h3C, 1'b0);    // -16 -> phys 0

    // Bounds: out-of-range write dropped, out-of-range read returns 0.
    do_write(6'd16, 8'h5A, 1'b1);
    do_write(6'h2F, 8'h5B, 1'b1);   // -17
    do_read(6'd0, 8'h3C, 1'b0);
    do_read(6'd15, 8'hA5, 1'b0);
    do_read(6'h2F, 8'h00, 1'b1);    // -17
    do_read(6'd16, 8'h00, 1'b1);

    // Read-during-write, aliased indices 3 and -13.
    WE = 1'b1; WADDR = 6'd3; D = 8'h77;
    RE = 1'b1; RADDR = 6'h33;
    step();
    WE = 1'b0; RE = 1'b0;
    check("rdw_qv0", 32'(qv0), 32'd1);
    check("rdw_q0",  32'(q0),  32'h77);
    check("rdw_qv1_early", 32'(qv1), 32'd0);
    step();
    check("rdw_qv1", 32'(qv1), 32'd1);
    check("rdw_q1",  32'(q1),  32'h77);
    do_read(6'd3, 8'h77, 1'b0);

    // CLR during continuous traffic.
    do_write(6'd5, 8'h42, 1'b0);
    CLR = 1'b1;
    WE = 1'b1; WADDR = 6'd7; D = 8'h99;
    RE = 1'b1; RADDR = 6'd5;
    step();
    CLR = 1'b0;
    WADDR = 6'd20;                   // out of range, must not flag while busy
    check("clr_busy", 32'(busy0), 32'd1);
    check("clr_pre_qv0", 32'(qv0), 32'd1);
    check("clr_pre_q0",  32'(q0),  32'h42);
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      check("clr_werr0", 32'(werr0), 32'd0);
      if (n >= 2) check("clr_qv0", 32'(qv0), 32'd0);
      if (n == 2) check("clr_pre_q1", 32'(q1), 32'h42);
      if (n >= 3) check("clr_qv1", 32'(qv1), 32'd0);
      step();
    end
    WE = 1'b0; RE = 1'b0;
    check("clr_cycles", n, 32'd16);
    do_read(6'd5, 8'h00, 1'b0);
    do_read(6'd7, 8'h00, 1'b0);
    do_read(6'h3F, 8'h00, 1'b0);

    // Reset in the middle of a clear.
    do_write(6'd2, 8'h66, 1'b0);
    do_read(6'd2, 8'h66, 1'b0);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    repeat (6) step();
    check("mid_busy", 32'(busy0), 32'd1);
    RST = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    step();
    step();
    check_reset_outputs("mid_rst_hold");
    RST = 1'b1;
    count_busy(n);
    check("mid_clear_cycles", n, 32'd16);
    do_read(6'd2, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
